// File: rtl/div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_sequencer
// Brief    : Sequential unsigned restoring divider, one quotient bit per two
//            clocks (SHIFT then SUB), with divide-by-zero short cut.
// Revision : 1.0 - initial release
// ============================================================================
module div_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] C_CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] C_CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_SUB   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [WIDTH:0]    r_a;
  logic [WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]  r_m;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH:0]    w_diff;
  logic              w_last;
  logic              w_div_zero;

  assign w_diff     = r_a - {1'b0, r_m};
  assign w_last     = (r_cnt == C_CNT_LAST);
  assign w_div_zero = (divisor == '0);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = w_div_zero ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        busy   = 1'b1;
        w_next = S_SUB;
      end
      S_SUB: begin
        busy   = 1'b1;
        w_next = w_last ? S_DONE : S_SHIFT;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // A negative trial difference leaves A untouched, so restoring is a select.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a         <= '0;
      r_q         <= '0;
      r_m         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_div_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              r_a   <= '0;
              r_q   <= dividend;
              r_m   <= divisor;
              r_cnt <= C_CNT_INIT;
            end
          end
        end
        S_SHIFT: begin
          {r_a, r_q} <= {r_a[WIDTH-1:0], r_q, 1'b0};
        end
        S_SUB: begin
          r_cnt <= r_cnt - C_CNT_LAST;
          if (!w_diff[WIDTH]) begin
            r_a    <= w_diff;
            r_q[0] <= 1'b1;
          end else begin
            r_q[0] <= 1'b0;
          end
          if (w_last) begin
            quotient    <= {r_q[WIDTH-1:1], ~w_diff[WIDTH]};
            remainder   <= w_diff[WIDTH] ? r_a[WIDTH-1:0] : w_diff[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_sequencer
// Brief    : Directed self-checking bench for div_sequencer (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] dividend;
  logic [7:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] m_q   = 8'd0;
  logic [7:0] m_r   = 8'd0;
  logic       m_dbz = 1'b0;

  div_sequencer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_div(input string tag, input logic [7:0] dd, input logic [7:0] dv,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                        input int elat, input bit poke);
    int lat;
    int nbusy;
    int ndone;
    start    = 1'b1;
    dividend = dd;
    divisor  = dv;
    step();
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (lat == 5) begin
        chk({tag, " hold_q"}, quotient, m_q);
        chk({tag, " hold_r"}, remainder, m_r);
        chk({tag, " hold_dbz"}, div_by_zero, m_dbz);
      end
      if (poke && (lat == 3 || lat == 10)) begin
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd2;
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    chk({tag, " latency"}, lat, elat);
    chk({tag, " busy_cycles"}, nbusy, (elat == 0) ? 0 : elat);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    chk({tag, " quotient"}, quotient, eq);
    chk({tag, " remainder"}, remainder, er);
    chk({tag, " div_by_zero"}, div_by_zero, edbz);
    m_q   = eq;
    m_r   = er;
    m_dbz = edbz;
    ndone = 0;
    repeat (20) begin
      step();
      if (done || busy) ndone++;
    end
    chk({tag, " idle_after_done"}, ndone, 0);
    chk({tag, " held_q"}, quotient, eq);
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] rv;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = 8'd0;
    divisor  = 8'd0;
    repeat (2) step();
    reset = 1'b0;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset quotient", quotient, 8'd0);
    chk("reset remainder", remainder, 8'd0);
    chk("reset dbz", div_by_zero, 1'b0);

    do_div("100/7",   8'd100, 8'd7, 8'd14,  8'd2,   1'b0, 16, 1'b0);
    do_div("255/1",   8'd255, 8'd1, 8'd255, 8'd0,   1'b0, 16, 1'b0);
    do_div("5/9",     8'd5,   8'd9, 8'd0,   8'd5,   1'b0, 16, 1'b0);
    do_div("200/0",   8'd200, 8'd0, 8'hFF,  8'd200, 1'b1, 0,  1'b0);
    do_div("0/0",     8'd0,   8'd0, 8'hFF,  8'd0,   1'b1, 0,  1'b0);
    do_div("255/255", 8'd255, 8'd255, 8'd1, 8'd0,   1'b0, 16, 1'b0);
    do_div("0/5",     8'd0,   8'd5, 8'd0,   8'd0,   1'b0, 16, 1'b0);
    do_div("254/255", 8'd254, 8'd255, 8'd0, 8'd254, 1'b0, 16, 1'b0);
    do_div("255/16",  8'd255, 8'd16, 8'd15, 8'd15,  1'b0, 16, 1'b0);
    do_div("100/7 poke", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16, 1'b1);

    // Mid-operation reset, then a clean division.
    start    = 1'b1;
    dividend = 8'd255;
    divisor  = 8'd16;
    step();
    start = 1'b0;
    repeat (6) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset busy", busy, 1'b0);
    chk("midreset done", done, 1'b0);
    chk("midreset quotient", quotient, 8'd0);
    chk("midreset remainder", remainder, 8'd0);
    chk("midreset dbz", div_by_zero, 1'b0);
    m_q   = 8'd0;
    m_r   = 8'd0;
    m_dbz = 1'b0;
    do_div("post-reset 100/7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 16, 1'b0);

    for (int i = 0; i < 24; i++) begin
      rd = 8'($urandom_range(0, 255));
      rv = (i % 8 == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      if (rv == 8'd0)
        do_div("rand", rd, rv, 8'hFF, rd, 1'b1, 0, 1'b0);
      else
        do_div("rand", rd, rv, rd / rv, rd % rv, 1'b0, 16, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
